// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ID->EX issue stage for the MIPS pipeline. Decodes the ID instruction into
// the ALU control code, selects and extends the operands, and buffers the
// resulting {in1, in2, ctrl, illegal} triple in a 2-entry skid buffer.
// id_ready is registered, so EX back-pressure has no combinational path
// into ID.
//
// Parameters:
//   DEPTH      - skid entries; only 2 is supported
//   SHAMT_MASK - 1: variable shifts use rs[4:0]; 0: full rs_data
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   id_valid / id_ready   - ID-side handshake (id_ready registered)
//   id_instr              - instruction word
//   rs_data / rt_data     - forwarded register operands, sampled at accept
//   flush                 - synchronous kill of all buffered entries
//   ex_valid / ex_ready   - EX-side handshake on the head entry
//   ex_in1, ex_in2        - ALU operands
//   ex_alu_ctrl           - 4-bit ALU control code
//   ex_illegal            - head entry decoded as unsupported
//
// Optional: define ALU_ISSUE_PERF_EN to add perf_issued (pop count) and
// perf_stall (cycles with ex_valid & !ex_ready) counters.

module alu_issue_stage #(
    parameter int unsigned DEPTH      = 2,
    parameter bit          SHAMT_MASK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [3:0]  ex_alu_ctrl,
    output logic        ex_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1110;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  ctrl;
        logic        illegal;
    } entry_t;

    // State encoding equals the number of occupied entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'(DEPTH)
    } state_t;

    state_t state, nstate;
    entry_t head, tail, dec;

    logic accept, pop;

    // ---------------------------------------------------------------- decode
    logic [5:0]  op, funct;
    logic [31:0] sext, zext, shamt_ext, shv;
    logic        dec_ok;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_a, dec_b;

    // rs/rt/rd fields are not needed: operands arrive already forwarded.
    logic unused_fields;
    assign unused_fields = ^id_instr[25:16];

    assign op        = id_instr[31:26];
    assign funct     = id_instr[5:0];
    assign sext      = {{16{id_instr[15]}}, id_instr[15:0]};
    assign zext      = {16'h0000, id_instr[15:0]};
    assign shamt_ext = {27'd0, id_instr[10:6]};
    assign shv       = SHAMT_MASK ? {27'd0, rs_data[4:0]} : rs_data;

    always_comb begin
        dec_ok   = 1'b1;
        dec_ctrl = ALU_ILL;
        dec_a    = rs_data;
        dec_b    = rt_data;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: dec_ctrl = ALU_ADD;
                    6'h22, 6'h23: dec_ctrl = ALU_SUB;
                    6'h24:        dec_ctrl = ALU_AND;
                    6'h25:        dec_ctrl = ALU_OR;
                    6'h26:        dec_ctrl = ALU_XOR;
                    6'h27:        dec_ctrl = ALU_NOR;
                    6'h2A:        dec_ctrl = ALU_SLT;
                    6'h2B:        dec_ctrl = ALU_SLTU;
                    6'h00, 6'h02, 6'h03: begin
                        dec_ctrl = (funct == 6'h00) ? ALU_SLL :
                                   (funct == 6'h02) ? ALU_SRL : ALU_SRA;
                        dec_a    = rt_data;
                        dec_b    = shamt_ext;
                    end
                    6'h04, 6'h06, 6'h07: begin
                        dec_ctrl = (funct == 6'h04) ? ALU_SLL :
                                   (funct == 6'h06) ? ALU_SRL : ALU_SRA;
                        dec_a    = rt_data;
                        dec_b    = shv;
                    end
                    default: dec_ok = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: begin
                dec_ctrl = ALU_ADD;
                dec_b    = sext;
            end
            6'h0A: begin
                dec_ctrl = ALU_SLT;
                dec_b    = sext;
            end
            6'h0B: begin
                dec_ctrl = ALU_SLTU;
                dec_b    = sext;
            end
            6'h0C: begin
                dec_ctrl = ALU_AND;
                dec_b    = zext;
            end
            6'h0D: begin
                dec_ctrl = ALU_OR;
                dec_b    = zext;
            end
            6'h0E: begin
                dec_ctrl = ALU_XOR;
                dec_b    = zext;
            end
            6'h0F: begin
                dec_ctrl = ALU_SLL;
                dec_a    = zext;
                dec_b    = 32'd16;
            end
            6'h04, 6'h05: dec_ctrl = ALU_SUB;
            default: dec_ok = 1'b0;
        endcase

        if (dec_ok) begin
            dec = '{in1: dec_a, in2: dec_b, ctrl: dec_ctrl, illegal: 1'b0};
        end else begin
            dec = '{in1: '0, in2: '0, ctrl: ALU_ILL, illegal: 1'b1};
        end
    end

    // ------------------------------------------------------------ skid buffer
    assign accept = id_valid & id_ready;
    assign pop    = ex_valid & ex_ready;

    always_comb begin
        nstate = state;
        if (flush) begin
            nstate = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) nstate = ONE;
                ONE: begin
                    if (accept && !pop) nstate = FULL;
                    else if (!accept && pop) nstate = EMPTY;
                end
                FULL:    if (pop) nstate = ONE;
                default: nstate = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            id_ready <= 1'b1;
            ex_valid <= 1'b0;
            head     <= '0;
            tail     <= '0;
        end else begin
            state    <= nstate;
            id_ready <= (nstate != FULL);
            ex_valid <= (nstate != EMPTY);
            if (!flush) begin
                case (state)
                    EMPTY: if (accept) head <= dec;
                    ONE: begin
                        // With a same-cycle pop the new entry goes straight to head.
                        if (accept && pop)       head <= dec;
                        else if (accept && !pop) tail <= dec;
                    end
                    FULL:  if (pop) head <= tail;
                    default: ;
                endcase
            end
        end
    end

    assign ex_in1      = head.in1;
    assign ex_in2      = head.in2;
    assign ex_alu_ctrl = head.ctrl;
    assign ex_illegal  = head.illegal;

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (pop)                  perf_issued <= perf_issued + 32'd1;
            if (ex_valid && !ex_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: a queue-based reference model of the
// decode rules and FIFO behaviour is checked against the DUT on every
// negative clock edge, plus directed vectors with literal expectations.

module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    int unsigned tests = 0;
    int unsigned fails = 0;

    alu_issue_stage #(.DEPTH(2), .SHAMT_MASK(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_in1      (ex_in1),
        .ex_in2      (ex_in2),
        .ex_alu_ctrl (ex_alu_ctrl),
        .ex_illegal  (ex_illegal)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        logic        ill;
    } exp_t;

    exp_t q[$];

    function automatic exp_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.ctrl = c; e.in1 = a; e.in2 = b; e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic [31:0] se, ze, sh;
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0000, ins[15:0]};
        sh = 32'(ins[10:6]);
        e.ctrl = 4'hF; e.in1 = 32'd0; e.in2 = 32'd0; e.ill = 1'b1;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20, 6'h21: e = mk(4'b0010, rs, rt);
                6'h22, 6'h23: e = mk(4'b0110, rs, rt);
                6'h24: e = mk(4'b0000, rs, rt);
                6'h25: e = mk(4'b0001, rs, rt);
                6'h26: e = mk(4'b1001, rs, rt);
                6'h27: e = mk(4'b1100, rs, rt);
                6'h2A: e = mk(4'b0111, rs, rt);
                6'h2B: e = mk(4'b1110, rs, rt);
                6'h00: e = mk(4'b1010, rt, sh);
                6'h02: e = mk(4'b0011, rt, sh);
                6'h03: e = mk(4'b1011, rt, sh);
                6'h04: e = mk(4'b1010, rt, rs & 32'h1F);
                6'h06: e = mk(4'b0011, rt, rs & 32'h1F);
                6'h07: e = mk(4'b1011, rt, rs & 32'h1F);
                default: ;
            endcase
            6'h08, 6'h09, 6'h23, 6'h2B: e = mk(4'b0010, rs, se);
            6'h0A: e = mk(4'b0111, rs, se);
            6'h0B: e = mk(4'b1110, rs, se);
            6'h0C: e = mk(4'b0000, rs, ze);
            6'h0D: e = mk(4'b0001, rs, ze);
            6'h0E: e = mk(4'b1001, rs, ze);
            6'h0F: e = mk(4'b1010, ze, 32'd16);
            6'h04, 6'h05: e = mk(4'b0110, rs, rt);
            default: ;
        endcase
        return e;
    endfunction

    bit m_acc, m_pop;

    always @(negedge rst_n) q.delete();

    always @(posedge clk) begin
        if (rst_n) begin
            m_acc = id_valid && (q.size() < 2);
            m_pop = (q.size() != 0) && ex_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) q.delete(0);
                if (m_acc) q.push_back(model(id_instr, rs_data, rt_data));
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_id_ready", 32'(id_ready), 32'(q.size() < 2));
        chk("cmp_ex_valid", 32'(ex_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("cmp_in1", ex_in1, q[0].in1);
            chk("cmp_in2", ex_in2, q[0].in2);
            chk("cmp_ctrl", 32'(ex_alu_ctrl), 32'(q[0].ctrl));
            chk("cmp_illegal", 32'(ex_illegal), 32'(q[0].ill));
        end else if (!rst_n) begin
            chk("rst_in1", ex_in1, 32'd0);
            chk("rst_in2", ex_in2, 32'd0);
            chk("rst_ctrl", 32'(ex_alu_ctrl), 32'd0);
            chk("rst_illegal", 32'(ex_illegal), 32'd0);
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        id_valid = v; id_instr = ins; rs_data = rs; rt_data = rt;
    endtask

    task automatic head_is(input string name, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic ill);
        chk({name, "_valid"}, 32'(ex_valid), 32'd1);
        chk({name, "_ctrl"}, 32'(ex_alu_ctrl), 32'(c));
        chk({name, "_in1"}, ex_in1, a);
        chk({name, "_in2"}, ex_in2, b);
        chk({name, "_ill"}, 32'(ex_illegal), 32'(ill));
    endtask

    localparam logic [31:0] I_ADD  = 32'h01095020;
    localparam logic [31:0] I_SUB  = 32'h01095022;
    localparam logic [31:0] I_LW   = 32'h8D090010;
    localparam logic [31:0] I_BEQ  = 32'h11090004;

    logic [31:0] tbl_ins [12];
    logic [31:0] tbl_rs  [12];
    logic [31:0] tbl_rt  [12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        chk("reset_id_ready", 32'(id_ready), 32'd1);
        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_ctrl", 32'(ex_alu_ctrl), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-issue decode vectors, EX always ready.
        ex_ready = 1'b1;
        drive(1'b1, 32'h2631FFFF, 32'd5, 32'd0);        // addiu
        tick();
        head_is("addiu", 4'b0010, 32'd5, 32'hFFFFFFFF, 1'b0);
        drive(1'b1, 32'h00094100, 32'd0, 32'd1);        // sll rd, rt, 4
        tick();
        head_is("sll", 4'b1010, 32'd1, 32'd4, 1'b0);
        drive(1'b1, 32'h01494007, 32'h123, 32'h80000000); // srav
        tick();
        head_is("srav", 4'b1011, 32'h80000000, 32'd3, 1'b0);
        drive(1'b1, 32'h3C01ABCD, 32'h5555, 32'd0);     // lui
        tick();
        head_is("lui", 4'b1010, 32'h0000ABCD, 32'd16, 1'b0);
        drive(1'b1, 32'h34228000, 32'h77, 32'd0);       // ori
        tick();
        head_is("ori", 4'b0001, 32'h77, 32'h00008000, 1'b0);
        drive(1'b1, 32'hFC000000, 32'h1234, 32'h5678);  // undefined op 0x3F
        tick();
        head_is("illegal", 4'b1111, 32'd0, 32'd0, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        chk("drain_ex_valid", 32'(ex_valid), 32'd0);

        // Model-checked sweep of the remaining decode rules.
        tbl_ins[0]  = 32'h0109502A; tbl_rs[0]  = 32'hFFFFFFFF; tbl_rt[0]  = 32'd1; // slt
        tbl_ins[1]  = 32'h0109502B; tbl_rs[1]  = 32'd3;        tbl_rt[1]  = 32'd9; // sltu
        tbl_ins[2]  = 32'h01095026; tbl_rs[2]  = 32'hF0F0;     tbl_rt[2]  = 32'h0FF0; // xor
        tbl_ins[3]  = 32'h01095027; tbl_rs[3]  = 32'h1;        tbl_rt[3]  = 32'h2; // nor
        tbl_ins[4]  = 32'h000947C2; tbl_rs[4]  = 32'd0;        tbl_rt[4]  = 32'h80; // srl 31
        tbl_ins[5]  = 32'h01094004; tbl_rs[5]  = 32'hFFFFFFE5; tbl_rt[5]  = 32'd7; // sllv
        tbl_ins[6]  = 32'h3122F00F; tbl_rs[6]  = 32'hFFFF;     tbl_rt[6]  = 32'd0; // andi
        tbl_ins[7]  = 32'h2D228000; tbl_rs[7]  = 32'd4;        tbl_rt[7]  = 32'd0; // sltiu
        tbl_ins[8]  = 32'hAD09FFF0; tbl_rs[8]  = 32'h100;      tbl_rt[8]  = 32'd0; // sw
        tbl_ins[9]  = 32'h15090008; tbl_rs[9]  = 32'd6;        tbl_rt[9]  = 32'd6; // bne
        tbl_ins[10] = 32'h0109503F; tbl_rs[10] = 32'd1;        tbl_rt[10] = 32'd2; // bad funct
        tbl_ins[11] = 32'h08000010; tbl_rs[11] = 32'd1;        tbl_rt[11] = 32'd2; // j: unsupported
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl_ins[i], tbl_rs[i], tbl_rt[i]);
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        tick();

        // Back-to-back issue under back-pressure.
        ex_ready = 1'b0;
        drive(1'b1, I_ADD, 32'd10, 32'd20);
        tick();
        chk("b2b_ready_a", 32'(id_ready), 32'd1);
        head_is("b2b_a", 4'b0010, 32'd10, 32'd20, 1'b0);
        drive(1'b1, I_SUB, 32'd7, 32'd3);
        tick();
        chk("b2b_ready_full", 32'(id_ready), 32'd0);
        head_is("b2b_hold_a", 4'b0010, 32'd10, 32'd20, 1'b0);
        drive(1'b1, I_LW, 32'h1000, 32'd0);
        tick();
        chk("b2b_ready_still0", 32'(id_ready), 32'd0);
        ex_ready = 1'b1;
        tick();
        chk("b2b_ready_back", 32'(id_ready), 32'd1);
        head_is("b2b_b", 4'b0110, 32'd7, 32'd3, 1'b0);
        tick();
        head_is("b2b_c", 4'b0010, 32'h1000, 32'h10, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        chk("b2b_empty", 32'(ex_valid), 32'd0);

        // Flush while FULL with an instruction presented.
        ex_ready = 1'b0;
        drive(1'b1, I_ADD, 32'd1, 32'd2);
        tick();
        drive(1'b1, I_SUB, 32'd3, 32'd4);
        tick();
        drive(1'b1, I_BEQ, 32'd5, 32'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_full_valid", 32'(ex_valid), 32'd0);
        chk("flush_full_ready", 32'(id_ready), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        ex_ready = 1'b1;
        tick();
        tick();
        chk("flush_never_issued", 32'(ex_valid), 32'd0);

        // Flush in ONE discards a same-cycle accept.
        ex_ready = 1'b0;
        drive(1'b1, I_ADD, 32'd1, 32'd2);
        tick();
        drive(1'b1, I_SUB, 32'd9, 32'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("flush_one_valid", 32'(ex_valid), 32'd0);
        tick();
        chk("flush_one_stay", 32'(ex_valid), 32'd0);

        // Asynchronous reset while FULL.
        drive(1'b1, I_ADD, 32'd11, 32'd12);
        tick();
        drive(1'b1, 32'hFC000000, 32'd0, 32'd0);
        tick();
        chk("pre_rst_ready", 32'(id_ready), 32'd0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_ready", 32'(id_ready), 32'd1);
        chk("arst_in1", ex_in1, 32'd0);
        chk("arst_in2", ex_in2, 32'd0);
        chk("arst_ctrl", 32'(ex_alu_ctrl), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(ex_valid), 32'd0);
        chk("post_rst_ready", 32'(id_ready), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID→EX issue stage that produces the ALU's `in1`/`in2`/`ALUControl` triple for the MIPS pipeline. It decodes the ID-stage instruction into the ALU's 4-bit control code and selects/extends operands. Results are buffered in a 2-entry skid buffer with valid/ready handshakes on both sides, so `id_ready` is a registered signal and EX back-pressure never creates a combinational path into ID.

Parameters:
- DEPTH, 2, skid entries; fixed at 2, other values unsupported.
- SHAMT_MASK, 1, 1 = mask variable shift amounts to `rs[4:0]`; 0 = pass full `rs_data`.

Ports:
- clk, input, 1, clock
- rst_n, input, 1, asynchronous active-low reset
- id_valid, input, 1, ID presents an instruction
- id_ready, output, 1, stage can accept; registered
- id_instr, input, 32, MIPS instruction word
- rs_data, input, 32, rs register value (already forwarded)
- rt_data, input, 32, rt register value (already forwarded)
- flush, input, 1, synchronous kill of all buffered entries
- ex_valid, output, 1, head entry valid
- ex_ready, input, 1, EX consumes head this cycle
- ex_in1, output, 32, ALU `in1`
- ex_in2, output, 32, ALU `in2`
- ex_alu_ctrl, output, 4, ALU control code
- ex_illegal, output, 1, head entry decoded as unsupported

Behaviour:
- Reset (`rst_n`=0, async): buffer EMPTY; `id_ready`=1; `ex_valid`=0; `ex_in1`/`ex_in2`=0; `ex_alu_ctrl`=4'b0000; `ex_illegal`=0.
- ALU control codes (fixed): add 0010, sub 0110, and 0000, or 0001, slt 0111, xor 1001, sll 1010, sra 1011, nor 1100, sltu 1110, srl 0011, illegal 1111.
- R-type (op 0x00), decoded on funct:
  - add/addu (20/21) → add; sub/subu (22/23) → sub; and 24; or 25; xor 26; nor 27; slt 2A; sltu 2B.
  - For all of these: `in1`=rs, `in2`=rt.
- Shifts, which must follow the ALU's "in1 shifted by in2" order:
  - sll/srl/sra (00/02/03): `in1`=rt, `in2`={27'b0, shamt}.
  - sllv/srlv/srav (04/06/07): `in1`=rt, `in2`={27'b0, rs[4:0]} when SHAMT_MASK=1.
- I-type:
  - addi/addiu (08/09) → add, `in2`=sign-extended imm.
  - slti 0A → slt, sign-extended imm.
  - sltiu 0B → sltu, sign-extended imm.
  - andi/ori/xori (0C/0D/0E) → and/or/xor, zero-extended imm.
  - lui 0F → sll, `in1`={16'b0, imm}, `in2`=16.
  - lw 23 / sw 2B → add, `in1`=rs, `in2`=sign-extended imm.
  - beq/bne (04/05) → sub, `in1`=rs, `in2`=rt.
- Any other op/funct: ctrl=1111, `ex_illegal`=1, operands=0. It is still issued, not dropped.
- Accept = `id_valid` & `id_ready`. Pop = `ex_valid` & `ex_ready`.
- Skid FSM (count of occupied entries):
  - EMPTY: accept → ONE.
  - ONE: accept & !pop → FULL; accept & pop → ONE (new entry becomes head next cycle); pop only → EMPTY.
  - FULL: pop → ONE (tail promotes to head); no accept possible.
- `id_ready` = registered (next state != FULL). It deasserts the cycle after the buffer fills.
- Latency: accepted instruction appears on `ex_*` the next cycle when the buffer was empty. Otherwise ordering is strictly FIFO.
- Outputs are driven from the head register only; `ex_*` is stable while `ex_valid`=1 and `ex_ready`=0.
- `flush`=1: next state EMPTY, any same-cycle accept discarded, `id_ready`=1 next cycle. `ex_*` data regs may hold stale values, but `ex_valid`=0.
- Decode is combinational on ID inputs and captured at accept. `rs_data`/`rt_data` are sampled only at accept.
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro `ALU_ISSUE_PERF_EN`.
- When defined, adds outputs:
  - `perf_issued[31:0]`: count of pops, wraps at 2^32.
  - `perf_stall[31:0]`: cycles with `ex_valid`=1 and `ex_ready`=0.
  - Both counters reset to 0 and are not cleared by `flush`.
- When undefined, these ports and the counters are absent. Behaviour is otherwise identical.

Test Plan:
- addiu $t, $s, -1 (0x2631FFFF) with `rs`=5, `ex_ready`=1 → next cycle `ex_valid`=1, ctrl=0010, `in1`=5, `in2`=0xFFFFFFFF.
- sll rd, rt, 4 with `rt`=0x1 → ctrl=1010, `in1`=1, `in2`=4. srav with `rs`=0x123 (SHAMT_MASK=1) → `in2`=3, ctrl=1011.
- lui imm=0xABCD → ctrl=1010, `in1`=0xABCD, `in2`=16. ori imm=0x8000 → `in2`=0x00008000 (zero-extended).
- `ex_ready`=0, issue 3 instructions back-to-back:
  - First two are accepted and `id_ready`=0 after the second.
  - Then `ex_ready`=1 → pops in order A, B; `id_ready` returns to 1 the cycle after the first pop.
- FULL buffer with `flush`=1 while `id_valid`=1 → next cycle `ex_valid`=0, `id_ready`=1, and the flushed-cycle instruction is never issued.
- Undefined op 0x3F → ctrl=1111, `ex_illegal`=1, `in1`=`in2`=0. Assert `rst_n`=0 while FULL → outputs return to reset values immediately, without waiting for a clock edge.
